// File: rtl/cc_loader_if.sv
// Bundles the loader's command-bus, RAM-read and cache-write signals.
// master = the loader, slave = the surrounding system (bus master, RAM, core).
interface cc_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 6
);
  logic              cmdValid;
  logic [3:0]        cmdOp;
  logic [ADDR_W-1:0] cmdData;
  logic              cmdReady;
  logic              ramReq;
  logic [ADDR_W-1:0] ramAddr;
  logic              ramAck;
  logic [DATA_W-1:0] ramData;
  logic              cacheWe;
  logic [IDX_W-1:0]  cacheAddr;
  logic [DATA_W-1:0] cacheData;
  logic              coreStall;
  logic              coreHalt;
  logic              loadDone;
  logic [ADDR_W-1:0] cachedBase;

  modport master (
    input  cmdValid, cmdOp, cmdData, ramAck, ramData,
    output cmdReady, ramReq, ramAddr, cacheWe, cacheAddr, cacheData,
           coreStall, coreHalt, loadDone, cachedBase
  );
  modport slave (
    output cmdValid, cmdOp, cmdData, ramAck, ramData,
    input  cmdReady, ramReq, ramAddr, cacheWe, cacheAddr, cacheData,
           coreStall, coreHalt, loadDone, cachedBase
  );
endinterface

// File: rtl/cc_loader.sv
// Code-cache loader: copies a window of RAM words into a core's local cache.
// Optional macro CC_SKIP_HIT_EN: taken jumps to the already-cached window skip the reload.
module cc_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic        fastClk,
  input  logic        rst,
  cc_loader_if.master bus
);
  typedef enum logic [1:0] {S_INIT, S_IDLE, S_LOAD, S_DONE} state_t;
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

  state_t            state_q;
  logic              ramReq_q, cacheWe_q, coreStall_q, coreHalt_q, cmdReady_q, loadDone_q;
  logic [ADDR_W-1:0] ramAddr_q, cachedBase_q, base_q;
  logic [IDX_W-1:0]  cacheAddr_q, idx_q;
  logic [DATA_W-1:0] cacheData_q, a_q, b_q;
  logic [IDX_W:0]    len_q;

  logic           acc_d, take_d, hit_d, last_d;
  logic [IDX_W:0] rawLen_d, setLen_d;

  assign acc_d    = (state_q == S_IDLE) && bus.cmdValid && cmdReady_q;
  assign rawLen_d = bus.cmdData[IDX_W:0];
  assign setLen_d = (rawLen_d == '0 || rawLen_d > FULL) ? FULL : rawLen_d;
  assign last_d   = ({1'b0, idx_q} == len_q - (IDX_W+1)'(1));

  always_comb begin
    take_d = 1'b0;
    case (bus.cmdOp)
      4'd1:    take_d = 1'b1;
      4'd2:    take_d = (a_q == b_q);
      4'd3:    take_d = (a_q < b_q);
      default: take_d = 1'b0;
    endcase
  end

`ifdef CC_SKIP_HIT_EN
  // hitOk_q stays low until the first load completes, so no hit before that
  logic           hitOk_q;
  logic [IDX_W:0] lastLen_q;
  assign hit_d = hitOk_q && (bus.cmdData == cachedBase_q) && (len_q <= lastLen_q);
`else
  assign hit_d = 1'b0;
`endif

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      state_q      <= S_INIT;
      ramReq_q     <= 1'b0;
      ramAddr_q    <= '0;
      cacheWe_q    <= 1'b0;
      cacheAddr_q  <= '0;
      cacheData_q  <= '0;
      coreStall_q  <= 1'b1;
      coreHalt_q   <= 1'b0;
      cmdReady_q   <= 1'b0;
      loadDone_q   <= 1'b0;
      cachedBase_q <= '0;
      base_q       <= '0;
      len_q        <= FULL;
      a_q          <= '0;
      b_q          <= '0;
      idx_q        <= '0;
`ifdef CC_SKIP_HIT_EN
      hitOk_q      <= 1'b0;
      lastLen_q    <= FULL;
`endif
    end else begin
      cacheWe_q  <= 1'b0;
      loadDone_q <= 1'b0;
      case (state_q)
        S_INIT: begin
          base_q     <= '0;
          ramAddr_q  <= '0;
          ramReq_q   <= 1'b1;
          idx_q      <= '0;
          coreHalt_q <= 1'b0;
          state_q    <= S_LOAD;
        end
        S_IDLE: begin
          if (acc_d) begin
            case (bus.cmdOp)
              4'd0: coreHalt_q <= 1'b1;
              4'd1, 4'd2, 4'd3: begin
                if (take_d && hit_d) begin
                  // cached window already matches: report completion without touching RAM
                  coreHalt_q <= 1'b0;
                  cmdReady_q <= 1'b0;
                  loadDone_q <= 1'b1;
                  state_q    <= S_DONE;
                end else if (take_d) begin
                  base_q      <= bus.cmdData;
                  ramAddr_q   <= bus.cmdData;
                  ramReq_q    <= 1'b1;
                  idx_q       <= '0;
                  coreHalt_q  <= 1'b0;
                  cmdReady_q  <= 1'b0;
                  coreStall_q <= 1'b1;
                  state_q     <= S_LOAD;
                end
              end
              4'd4: len_q <= setLen_d;
              4'd5: a_q   <= bus.cmdData[DATA_W-1:0];
              4'd6: b_q   <= bus.cmdData[DATA_W-1:0];
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          if (ramReq_q && bus.ramAck) begin
            cacheWe_q   <= 1'b1;
            cacheAddr_q <= idx_q;
            cacheData_q <= bus.ramData;
            idx_q       <= idx_q + IDX_W'(1);
            ramAddr_q   <= ramAddr_q + ADDR_W'(1);
            if (last_d) begin
              ramReq_q     <= 1'b0;
              cachedBase_q <= base_q;
              loadDone_q   <= 1'b1;
              state_q      <= S_DONE;
`ifdef CC_SKIP_HIT_EN
              hitOk_q      <= 1'b1;
              lastLen_q    <= len_q;
`endif
            end
          end
        end
        S_DONE: begin
          cmdReady_q  <= 1'b1;
          coreStall_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.cmdReady   = cmdReady_q;
  assign bus.ramReq     = ramReq_q;
  assign bus.ramAddr    = ramAddr_q;
  assign bus.cacheWe    = cacheWe_q;
  assign bus.cacheAddr  = cacheAddr_q;
  assign bus.cacheData  = cacheData_q;
  assign bus.coreStall  = coreStall_q;
  assign bus.coreHalt   = coreHalt_q;
  assign bus.loadDone   = loadDone_q;
  assign bus.cachedBase = cachedBase_q;
endmodule
